// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage sitting directly in front of a combinational
//   instruction memory. Owns the PC, drives the IMEM read address and
//   registers the returned word into the IF/ID pipeline register. A small
//   run/halt FSM gates fetching. A sticky fault is raised when the PC
//   leaves the IMEM range.
//
//   Optional build macro: FETCH_MISALIGN_CHK_EN
//     defined   : a redirect whose target[1:0] != 0 is not taken. It raises
//                 fetch_fault and halts instead. Outside RUN it is ignored.
//     undefined : target[1:0] is forced to 2'b00 and the redirect proceeds.
//
// Ports
//   clk, reset         clock (rising edge), async active-high reset
//   start, halt_req    FSM control: IDLE/HALTED -> RUN, RUN -> HALTED
//   stall              hold PC and IF/ID
//   redirect_valid     taken branch/jump; redirect_target is its byte address
//   imem_addr          byte address to IMEM (always equal to pc)
//   imem_rdata         instruction returned combinationally for imem_addr
//   if_id_valid        IF/ID holds a real instruction
//   if_id_instr        fetched instruction (bubble when not valid)
//   if_id_pc           address of if_id_instr
//   if_id_pc_plus4     if_id_pc + 4
//   running            FSM is in RUN
//   fetch_fault        sticky fault flag; cleared by a restart from HALTED
//
// State table
//   state    | meaning
//   ST_IDLE  | out of reset, no fetch, waiting for start
//   ST_RUN   | fetching one word per cycle unless stalled
//   ST_HALTED| stopped by halt_req or a fault, waiting for start

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        running,
    output logic        fetch_fault
);

    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        valid_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] ifpc_nxt;
    logic [31:0] ifpc4_nxt;
    logic        fault_nxt;

    logic [31:0] redirect_pc;
    logic        redirect_bad;
    logic        range_fault;

    // Masking the low bits keeps every PC word aligned.
    assign redirect_pc = redirect_target & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    assign redirect_bad = 1'b0;
`endif

    assign range_fault = (pc[31:2] >= DEPTH_WORDS);

    assign imem_addr = pc;
    assign running   = (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = if_id_valid;
        instr_nxt = if_id_instr;
        ifpc_nxt  = if_id_pc;
        ifpc4_nxt = if_id_pc_plus4;
        fault_nxt = fetch_fault;

        case (state)
            ST_IDLE: begin
                valid_nxt = 1'b0;
                if (redirect_valid && !redirect_bad) begin
                    pc_nxt = redirect_pc;
                end
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over stall; the word at the old pc is dropped.
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    if (redirect_bad) begin
                        fault_nxt = 1'b1;
                        state_nxt = ST_HALTED;
                    end else begin
                        pc_nxt = redirect_pc;
                        if (halt_req) begin
                            state_nxt = ST_HALTED;
                        end
                    end
                end else if (range_fault) begin
                    fault_nxt = 1'b1;
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    state_nxt = ST_HALTED;
                end else if (halt_req) begin
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    state_nxt = ST_HALTED;
                end else if (!stall) begin
                    valid_nxt = 1'b1;
                    instr_nxt = imem_rdata;
                    ifpc_nxt  = pc;
                    ifpc4_nxt = pc + 32'd4;
                    pc_nxt    = pc + 32'd4;
                end
            end

            ST_HALTED: begin
                valid_nxt = 1'b0;
                if (redirect_valid && !redirect_bad) begin
                    pc_nxt = redirect_pc;
                end
                if (start && !halt_req) begin
                    state_nxt = ST_RUN;
                    fault_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= 32'h0000_0000;
            if_id_pc_plus4 <= 32'h0000_0004;
            fetch_fault    <= 1'b0;
        end else begin
            pc             <= pc_nxt;
            if_id_valid    <= valid_nxt;
            if_id_instr    <= instr_nxt;
            if_id_pc       <= ifpc_nxt;
            if_id_pc_plus4 <= ifpc4_nxt;
            fetch_fault    <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, halt_req, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
    logic        running, fetch_fault;

    logic [31:0] imem [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[7:2]];

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .halt_req        (halt_req),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .running         (running),
        .fetch_fault     (fetch_fault)
    );

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_HALTED} mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr, m_ifpc, m_ifpc4;
    logic        m_fault;

    typedef struct {
        logic [31:0] addr;
        logic        run;
        logic        flt;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
    } exp_t;
    exp_t exp_q[$];

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = NOP;
        m_ifpc  = 32'h0;
        m_ifpc4 = 32'h4;
        m_fault = 1'b0;
    endtask

    task automatic model_step(input logic st, hr, sl, rv, input logic [31:0] rt);
        bit misaligned;
        misaligned = (rt % 4) != 0;
        if (m_mode == M_RUN) begin
            if (rv) begin
                m_valid = 1'b0;
                m_instr = NOP;
                if (CHK && misaligned) begin
                    m_fault = 1'b1;
                    m_mode  = M_HALTED;
                end else begin
                    m_pc = rt - (rt % 4);
                    if (hr) m_mode = M_HALTED;
                end
            end else if (m_pc / 4 >= 64) begin
                m_fault = 1'b1;
                m_valid = 1'b0;
                m_mode  = M_HALTED;
            end else if (hr) begin
                m_valid = 1'b0;
                m_instr = NOP;
                m_mode  = M_HALTED;
            end else if (!sl) begin
                m_instr = imem[m_pc / 4];
                m_ifpc  = m_pc;
                m_ifpc4 = m_pc + 4;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end
        end else begin
            if (rv && !(CHK && misaligned)) m_pc = rt - (rt % 4);
            if (m_mode == M_IDLE && st) begin
                m_mode = M_RUN;
            end else if (m_mode == M_HALTED && st && !hr) begin
                m_mode  = M_RUN;
                m_fault = 1'b0;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.addr  = m_pc;
        e.run   = (m_mode == M_RUN);
        e.flt   = m_fault;
        e.vld   = m_valid;
        e.instr = m_instr;
        e.ipc   = m_ifpc;
        e.ipc4  = m_ifpc4;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_imem_addr", imem_addr, e.addr);
                chk("sb_running", 32'(running), 32'(e.run));
                chk("sb_fetch_fault", 32'(fetch_fault), 32'(e.flt));
                chk("sb_if_id_valid", 32'(if_id_valid), 32'(e.vld));
                if (e.vld) begin
                    chk("sb_if_id_instr", if_id_instr, e.instr);
                    chk("sb_if_id_pc", if_id_pc, e.ipc);
                    chk("sb_if_id_pc_plus4", if_id_pc_plus4, e.ipc4);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic st, hr, sl, rv, input logic [31:0] rt);
        @(negedge clk);
        start           = st;
        halt_req        = hr;
        stall           = sl;
        redirect_valid  = rv;
        redirect_target = rt;
        @(posedge clk);
        model_step(st, hr, sl, rv, rt);
        push_expected();
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, "_instr"}, if_id_instr, NOP);
        chk({tag, "_if_id_pc"}, if_id_pc, 32'h0);
        chk({tag, "_pc_plus4"}, if_id_pc_plus4, 32'h4);
        chk({tag, "_running"}, 32'(running), 32'h0);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'h0);
    endtask

    initial begin
        logic st, hr, sl, rv;
        logic [31:0] rt;

        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[1] = 32'h0050_0113;

        reset = 1'b1;
        start = 1'b0; halt_req = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        model_reset();
        #3;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        // start, two fetches: word @0x4 lands in IF/ID
        cycle(1, 0, 0, 0, 0);
        chk("start_running", 32'(running), 32'h1);
        chk("start_no_valid_yet", 32'(if_id_valid), 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("first_valid", 32'(if_id_valid), 32'h1);
        cycle(0, 0, 0, 0, 0);
        chk("fetch_pc4_pc", if_id_pc, 32'h4);
        chk("fetch_pc4_instr", if_id_instr, 32'h0050_0113);
        chk("fetch_pc4_valid", 32'(if_id_valid), 32'h1);

        // stall for three cycles, then release
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
        chk("stall_pc_hold", imem_addr, 32'h8);
        chk("stall_ifpc_hold", if_id_pc, 32'h4);
        cycle(0, 0, 0, 0, 0);
        chk("stall_release_pc1", imem_addr, 32'hC);
        cycle(0, 0, 0, 0, 0);
        chk("stall_release_pc2", imem_addr, 32'h10);

        // redirect together with stall
        cycle(0, 0, 1, 1, 32'h4C);
        chk("redir_pc", imem_addr, 32'h4C);
        chk("redir_valid", 32'(if_id_valid), 32'h0);
        chk("redir_instr_nop", if_id_instr, NOP);
        cycle(0, 0, 0, 0, 0);
        chk("redir_ifpc", if_id_pc, 32'h4C);
        chk("redir_ifinstr", if_id_instr, imem[19]);

        // misaligned redirect
        cycle(0, 0, 0, 1, 32'h4E);
        if (CHK) begin
            chk("misalign_fault", 32'(fetch_fault), 32'h1);
            chk("misalign_halted", 32'(running), 32'h0);
            cycle(1, 0, 0, 0, 0);
        end else begin
            chk("misalign_forced_pc", imem_addr, 32'h4C);
            chk("misalign_running", 32'(running), 32'h1);
        end

        // run off the end of IMEM
        cycle(0, 0, 0, 1, 32'hF8);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("range_pc_100", imem_addr, 32'h100);
        chk("range_last_ifpc", if_id_pc, 32'hFC);
        cycle(0, 0, 0, 0, 0);
        chk("range_fault", 32'(fetch_fault), 32'h1);
        chk("range_halted", 32'(running), 32'h0);
        chk("range_pc_hold", imem_addr, 32'h100);
        chk("range_valid", 32'(if_id_valid), 32'h0);
        cycle(1, 0, 0, 0, 0);
        chk("restart_running", 32'(running), 32'h1);
        chk("restart_fault_clr", 32'(fetch_fault), 32'h0);
        cycle(0, 0, 0, 1, 32'h0);
        chk("recover_running", 32'(running), 32'h1);

        // async reset while stalled in RUN
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        stall = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 3) == 0);
            hr = ($urandom_range(0, 19) == 0);
            sl = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0);
            rt = 32'($urandom_range(0, 66)) * 4;
            if ($urandom_range(0, 9) == 0 && (!CHK || m_mode == M_RUN))
                rt = rt + 32'($urandom_range(1, 3));
            cycle(st, hr, sl, rv, rt);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
